seg_scroll_buffer: RTL and testbench

SEG_SCROLL_BUFFER -- requirements
Module: seg_scroll_buffer

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_glyph_rom.sv | 33 +++
 rtl/seg_scroll_buffer.sv | 142 ++++++++++++++
 tb/tb_seg_scroll_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, character codes and state encoding for the scrolling 7-segment buffer
package seg_pkg;

  localparam int DIGITS = 8;
  localparam int SEG_W  = 7;

  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_DASH  = 5'h11;

  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam int TEST_LEN = 16;

  // Power-on demo message: 7..0 followed by F..8.
  function automatic logic [4:0] test_char(input int i);
    return (i < 8) ? 5'(7 - i) : 5'(23 - i);
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// rtl/seg_glyph_rom.sv - combinational character code to {g,f,e,d,c,b,a} segment pattern
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [4:0]       code,
  output logic [SEG_W-1:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      5'h00:   glyph = 7'b0111111;
      5'h01:   glyph = 7'b0000110;
      5'h02:   glyph = 7'b1011011;
      5'h03:   glyph = 7'b1001111;
      5'h04:   glyph = 7'b1100110;
      5'h05:   glyph = 7'b1101101;
      5'h06:   glyph = 7'b1111101;
      5'h07:   glyph = 7'b0000111;
      5'h08:   glyph = 7'b1111111;
      5'h09:   glyph = 7'b1101111;
      5'h0A:   glyph = 7'b1110111;
      5'h0B:   glyph = 7'b1111100;
      5'h0C:   glyph = 7'b0111001;
      5'h0D:   glyph = 7'b1011110;
      5'h0E:   glyph = 7'b1111001;
      5'h0F:   glyph = 7'b1110001;
      CH_DASH: glyph = GLYPH_DASH;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scroll_buffer.sv
// rtl/seg_scroll_buffer.sv - message buffer that shows up to 8 characters and scrolls longer messages
// Optional build macro SEG_TEST_PATTERN_EN: come out of reset already showing a 16-character demo message.
module seg_scroll_buffer
  import seg_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int SCROLL_DIV = 24'h80_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    char_valid_i,
  input  logic [4:0]              char_data_i,
  output logic                    char_ready_o,
  input  logic                    commit_i,
  input  logic                    clear_i,
  output logic [DIGITS*SEG_W-1:0] frame_o,
  output logic                    frame_upd_o,
  output logic [5:0]              count_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [5:0]  DEPTH_C   = 6'(DEPTH);
  localparam logic [23:0] TICK_LAST = 24'(SCROLL_DIV - 1);

`ifdef SEG_TEST_PATTERN_EN
  localparam state_t     RESET_STATE = ST_SHOW;
  localparam logic [5:0] RESET_COUNT = 6'(TEST_LEN);
  localparam logic       RESET_PEND  = 1'b1;

  if (DEPTH < TEST_LEN) begin : g_depth_check
    $error("seg_scroll_buffer: DEPTH must be at least 16 with the test pattern");
  end
`else
  localparam state_t     RESET_STATE = ST_IDLE;
  localparam logic [5:0] RESET_COUNT = 6'd0;
  localparam logic       RESET_PEND  = 1'b0;
`endif

  state_t                  state, state_next;
  logic [4:0]              mem [DEPTH];
  logic [5:0]              count, ptr;
  logic [23:0]             tick;
  logic                    ready_en, refresh_pend;
  logic                    wr, commit_go, scroll_on, step;
  logic [5:0]              idx   [DIGITS];
  logic [4:0]              codes [DIGITS];
  logic [DIGITS*SEG_W-1:0] composed;

  assign count_o   = count;
  assign wr        = rst_n_i && !clear_i && char_valid_i && char_ready_o;
  assign commit_go = !clear_i && (state == ST_LOAD) && commit_i;
  assign scroll_on = (state == ST_SHOW) && (count > 6'(DIGITS));
  assign step      = scroll_on && (tick == TICK_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= RESET_STATE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (wr) state_next = ST_LOAD;
        ST_LOAD: if (commit_i) state_next = ST_SHOW;
        ST_SHOW: state_next = ST_SHOW;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ready_en keeps the input closed during reset and opens it on the first cycle after release.
  always_comb begin
    char_ready_o = ready_en &&
                   ((state == ST_IDLE) || ((state == ST_LOAD) && (count < DEPTH_C)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count        <= RESET_COUNT;
      ptr          <= '0;
      tick         <= '0;
      frame_o      <= '0;
      frame_upd_o  <= 1'b0;
      ready_en     <= 1'b0;
      refresh_pend <= RESET_PEND;
    end else begin
      ready_en    <= 1'b1;
      frame_upd_o <= 1'b0;
      if (clear_i) begin
        count        <= '0;
        ptr          <= '0;
        tick         <= '0;
        frame_o      <= '0;
        frame_upd_o  <= 1'b1;
        refresh_pend <= 1'b0;
      end else begin
        if (wr) count <= count + 6'd1;
        // Frame is rebuilt one cycle after a commit or pointer move, so it sees the settled pointer/count.
        if (refresh_pend) begin
          frame_o     <= composed;
          frame_upd_o <= 1'b1;
        end
        refresh_pend <= commit_go || step;
        if (step) begin
          tick <= '0;
          ptr  <= ((ptr + 6'd1) == count) ? 6'd0 : ptr + 6'd1;
        end else if (scroll_on) begin
          tick <= tick + 24'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
`ifdef SEG_TEST_PATTERN_EN
    if (!rst_n_i) begin
      for (int i = 0; i < TEST_LEN; i++) mem[i] <= test_char(i);
    end else
`endif
    if (wr) mem[count[AW-1:0]] <= char_data_i;
  end

  // ptr < count and k < 8, so a single conditional subtract gives (ptr+k) mod count once scrolling.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      idx[k] = ptr + 6'(k);
      if (idx[k] >= count) idx[k] = idx[k] - count;
      codes[k] = (6'(k) < count) ? mem[idx[k][AW-1:0]] : CH_BLANK;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg_glyph_rom u_rom (
      .code  (codes[k]),
      .glyph (composed[k*SEG_W +: SEG_W])
    );
  end

endmodule

// File: tb/tb_seg_scroll_buffer.sv
// tb/tb_seg_scroll_buffer.sv - directed vector table plus scroll, fill, clear and reset sequences
module tb_seg_scroll_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_valid;
  logic [4:0]  char_data;
  logic        char_ready;
  logic        commit;
  logic        clear;
  logic [55:0] frame;
  logic        frame_upd;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;

  seg_scroll_buffer #(.DEPTH(16), .SCROLL_DIV(4)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .char_valid_i (char_valid),
    .char_data_i  (char_data),
    .char_ready_o (char_ready),
    .commit_i     (commit),
    .clear_i      (clear),
    .frame_o      (frame),
    .frame_upd_o  (frame_upd),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  d;
    logic        cm;
    logic        cl;
    logic [5:0]  cnt;
    logic        rdy;
    logic        upd;
    logic [55:0] frm;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [6:0] gl(input int c);
    case (c)
      0: return 7'b0111111;   1: return 7'b0000110;
      2: return 7'b1011011;   3: return 7'b1001111;
      4: return 7'b1100110;   5: return 7'b1101101;
      6: return 7'b1111101;   7: return 7'b0000111;
      8: return 7'b1111111;   9: return 7'b1101111;
      10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b0111001;  13: return 7'b1011110;
      14: return 7'b1111001;  15: return 7'b1110001;
      17: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic cm, input logic cl);
    char_valid = v;
    char_data  = d;
    commit     = cm;
    clear      = cl;
  endtask

  task automatic wait_upd(output int cyc);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      cyc++;
      if (frame_upd) break;
    end
  endtask

  logic [55:0] f3;
  logic [55:0] exp_f;
  int          cyc;

  initial begin
    f3 = {35'd0, gl(3), gl(2), gl(1)};
    vecs[0]  = '{1'b1, 5'h01, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 56'd0};
    vecs[1]  = '{1'b1, 5'h02, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0, 56'd0};
    vecs[2]  = '{1'b1, 5'h03, 1'b0, 1'b0, 6'd3, 1'b1, 1'b0, 56'd0};
    vecs[3]  = '{1'b0, 5'h00, 1'b1, 1'b0, 6'd3, 1'b0, 1'b0, 56'd0};
    vecs[4]  = '{1'b0, 5'h00, 1'b0, 1'b0, 6'd3, 1'b0, 1'b1, f3};
    vecs[5]  = '{1'b0, 5'h00, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0, f3};
    vecs[6]  = '{1'b0, 5'h00, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0, f3};
    vecs[7]  = '{1'b1, 5'h07, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0, f3};
    vecs[8]  = '{1'b0, 5'h00, 1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 56'd0};
    vecs[9]  = '{1'b0, 5'h00, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 56'd0};
    vecs[10] = '{1'b1, 5'h05, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 56'd0};
    vecs[11] = '{1'b1, 5'h06, 1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 56'd0};
    vecs[12] = '{1'b0, 5'h00, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 56'd0};
    vecs[13] = '{1'b0, 5'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 56'd0};
    vecs[14] = '{1'b1, 5'h09, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 56'd0};
    vecs[15] = '{1'b0, 5'h00, 1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 56'd0};

    rst_n = 1'b0;
    drive(1'b0, 5'h00, 1'b0, 1'b0);
    step();
    step();
`ifdef SEG_TEST_PATTERN_EN
    chk("rst_count", 64'(count), 64'd16);
    chk("rst_ready", 64'(char_ready), 64'd0);
    chk("rst_upd", 64'(frame_upd), 64'd0);
    chk("rst_frame", 64'(frame), 64'd0);
    rst_n = 1'b1;
    step();
    chk("tp_upd", 64'(frame_upd), 64'd1);
    chk("tp_count", 64'(count), 64'd16);
    chk("tp_digit0", 64'(frame[6:0]), 64'(7'b0000111));
    wait_upd(cyc);
    chk("tp_interval", 64'(cyc), 64'd4);
    chk("tp_digit0_step", 64'(frame[6:0]), 64'(gl(6)));
    drive(1'b0, 5'h00, 1'b0, 1'b1);
    step();
    drive(1'b0, 5'h00, 1'b0, 1'b0);
    step();
`else
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(char_ready), 64'd0);
    chk("rst_upd", 64'(frame_upd), 64'd0);
    chk("rst_frame", 64'(frame), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_ready", 64'(char_ready), 64'd1);
    chk("rel_upd", 64'(frame_upd), 64'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].cm, vecs[i].cl);
      step();
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d_ready", i), 64'(char_ready), 64'(vecs[i].rdy));
      chk($sformatf("vec%0d_upd", i), 64'(frame_upd), 64'(vecs[i].upd));
      chk($sformatf("vec%0d_frame", i), 64'(frame), 64'(vecs[i].frm));
    end
    drive(1'b0, 5'h00, 1'b0, 1'b0);

    // Fill to capacity, then hold a 17th character on the input.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'(i), 1'b0, 1'b0);
      step();
    end
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(char_ready), 64'd0);
    drive(1'b1, 5'h11, 1'b0, 1'b0);
    step();
    chk("overflow_count", 64'(count), 64'd16);
    chk("overflow_ready", 64'(char_ready), 64'd0);
    drive(1'b0, 5'h00, 1'b1, 1'b0);
    step();
    drive(1'b0, 5'h00, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 8; k++) exp_f[k*7 +: 7] = gl(k);
    chk("full_upd", 64'(frame_upd), 64'd1);
    chk("full_frame", 64'(frame), 64'(exp_f));
    wait_upd(cyc);
    chk("full_interval", 64'(cyc), 64'd4);
    for (int k = 0; k < 8; k++) exp_f[k*7 +: 7] = gl(k + 1);
    chk("full_frame_step1", 64'(frame), 64'(exp_f));
    drive(1'b0, 5'h00, 1'b0, 1'b1);
    step();
    chk("full_clear_count", 64'(count), 64'd0);
    chk("full_clear_frame", 64'(frame), 64'd0);

    // Ten characters; the last write shares its cycle with commit.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i), (i == 9), 1'b0);
      step();
    end
    drive(1'b0, 5'h00, 1'b0, 1'b0);
    chk("s10_count", 64'(count), 64'd10);
    step();
    chk("s10_first_upd", 64'(frame_upd), 64'd1);
    for (int k = 0; k < 8; k++) exp_f[k*7 +: 7] = gl(k);
    chk("s10_first_frame", 64'(frame), 64'(exp_f));
    for (int s = 1; s <= 10; s++) begin
      wait_upd(cyc);
      chk($sformatf("s10_interval%0d", s), 64'(cyc), 64'd4);
      chk($sformatf("s10_digit0_step%0d", s), 64'(frame[6:0]), 64'(gl(s % 10)));
      if (s == 3) chk("s10_wrap_digit7", 64'(frame[55:49]), 64'(7'b0111111));
    end
    chk("s10_back_to_zero", 64'(frame[6:0]), 64'(7'b0111111));

    // Reset pulse in the middle of the scroll.
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_frame", 64'(frame), 64'd0);
    chk("mid_rst_upd", 64'(frame_upd), 64'd0);
    chk("mid_rst_ready", 64'(char_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 64'(char_ready), 64'd1);
    chk("mid_rel_upd", 64'(frame_upd), 64'd0);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (frame_upd) cyc++;
    end
    chk("mid_no_residual_upd", 64'(cyc), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
